// File: rtl/fetch_decode_buf.sv
// Two-entry elastic buffer carrying {instr, incPC} from fetch to decode.
// Registered outputs only (no fall-through), flush on resolved branch, halt blocking.
module fetch_decode_buf #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [15:0] inInstr,
  input  logic [15:0] inIncPC,
  output logic        inReady,
  output logic        outValid,
  output logic [15:0] outInstr,
  output logic [15:0] outIncPC,
  input  logic        outReady,
  input  logic        flush,
  output logic        halt,
  output logic [1:0]  occupancy,
  output logic [15:0] stallCount
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0] entry [2];
  logic        wp;
  logic        rp;
  logic [1:0]  count;
  logic        haltSeen;
  logic        push;
  logic        pop;
  logic [31:0] head;

  // inReady never looks at outReady, so no combinational path decode -> fetch
  assign inReady   = (count != FULL) & ~haltSeen & ~flush;
  assign push      = inValid & inReady;
  assign outValid  = (count != 2'd0);
  assign pop       = outValid & outReady;
  assign head      = entry[rp];
  assign outInstr  = outValid ? head[31:16] : NOP_INSTR;
  assign outIncPC  = outValid ? head[15:0]  : 16'h0000;
  assign halt      = outValid & (head[31:27] == 5'b00000);
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      haltSeen <= 1'b0;
    end else if (flush) begin
      count    <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      haltSeen <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && (inInstr[15:11] == 5'b00000)) haltSeen <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is only observed while count covers it
  always_ff @(posedge clk) begin
    if (push) entry[wp] <= {inInstr, inIncPC};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= 16'h0000;
    end else if (inValid && !inReady && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Directed bench for fetch_decode_buf with a queue scoreboard and reference model.
module tb_fetch_decode_buf;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [15:0] inInstr;
  logic [15:0] inIncPC;
  logic        inReady;
  logic        outValid;
  logic [15:0] outInstr;
  logic [15:0] outIncPC;
  logic        outReady;
  logic        flush;
  logic        halt;
  logic [1:0]  occupancy;
  logic [15:0] stallCount;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  logic        mHalt = 1'b0;
  logic [15:0] mStall = 16'h0000;

  fetch_decode_buf #(.DEPTH(2), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inInstr(inInstr), .inIncPC(inIncPC),
    .inReady(inReady), .outValid(outValid), .outInstr(outInstr), .outIncPC(outIncPC),
    .outReady(outReady), .flush(flush), .halt(halt), .occupancy(occupancy),
    .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic        expReady;
    logic        expValid;
    logic [31:0] hd;
    expValid = (q.size() != 0);
    hd       = expValid ? q[0] : 32'h0800_0000;
    expReady = (q.size() != 2) && !mHalt && !flush;
    chk("inReady",    32'(inReady),    32'(expReady));
    chk("outValid",   32'(outValid),   32'(expValid));
    chk("outInstr",   32'(outInstr),   32'(hd[31:16]));
    chk("outIncPC",   32'(outIncPC),   32'(hd[15:0]));
    chk("halt",       32'(halt),       32'(expValid && (hd[31:27] == 5'b00000)));
    chk("occupancy",  32'(occupancy),  32'(q.size()));
    chk("stallCount", 32'(stallCount), 32'(mStall));
  endtask

  // Drive one cycle, check settled outputs, advance model, cross the edge.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic fl, input bit doChk = 1'b1);
    logic mReady;
    inValid = v; inInstr = ins; inIncPC = pc; outReady = ordy; flush = fl;
    #1;
    if (doChk) checkAll();
    mReady = (q.size() != 2) && !mHalt && !fl;
    if (v && !mReady && (mStall != 16'hFFFF)) mStall = mStall + 16'd1;
    if (fl) begin
      q.delete();
      mHalt = 1'b0;
    end else begin
      if (ordy && (q.size() != 0)) void'(q.pop_front());
      if (v && mReady) begin
        q.push_back({ins, pc});
        if (ins[15:11] == 5'b00000) mHalt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; inValid = 1'b0; inInstr = '0; inIncPC = '0; outReady = 1'b0; flush = 1'b0;
    #2;
    checkAll();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // stream at full rate
    cycle(1'b1, 16'h4001, 16'h0002, 1'b1, 1'b0);
    cycle(1'b1, 16'h4002, 16'h0004, 1'b1, 1'b0);
    cycle(1'b1, 16'h4003, 16'h0006, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // backpressure then drain
    cycle(1'b1, 16'h5001, 16'h0010, 1'b0, 1'b0);
    cycle(1'b1, 16'h5002, 16'h0012, 1'b0, 1'b0);
    cycle(1'b1, 16'h5003, 16'h0014, 1'b0, 1'b0);
    cycle(1'b1, 16'h5003, 16'h0014, 1'b0, 1'b0);
    cycle(1'b1, 16'h5003, 16'h0014, 1'b1, 1'b0);
    cycle(1'b1, 16'h5003, 16'h0014, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // simultaneous push/pop at count 1 across pointer wraps
    cycle(1'b1, 16'h6000, 16'h0020, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++)
      cycle(1'b1, 16'h6000 + 16'(i), 16'h0020 + 16'(2 * i), 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // flush while full, offered instruction must be dropped
    cycle(1'b1, 16'h7001, 16'h0030, 1'b0, 1'b0);
    cycle(1'b1, 16'h7002, 16'h0032, 1'b0, 1'b0);
    cycle(1'b1, 16'h7003, 16'h0034, 1'b1, 1'b1);
    cycle(1'b1, 16'h7004, 16'h0036, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // halt blocks fetch, queued entries drain, flush releases
    cycle(1'b1, 16'h8001, 16'h0040, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 16'h0042, 1'b0, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b0, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b1, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b0, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b1, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b0, 1'b0);
    cycle(1'b1, 16'h8003, 16'h0044, 1'b0, 1'b1);
    cycle(1'b1, 16'h8004, 16'h0046, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // async reset between edges while full
    cycle(1'b1, 16'h9001, 16'h0050, 1'b0, 1'b0);
    cycle(1'b1, 16'h9002, 16'h0052, 1'b0, 1'b0);
    cycle(1'b1, 16'h9003, 16'h0054, 1'b0, 1'b0);
    inValid = 1'b0;
    #1;
    chk("preResetOcc", 32'(occupancy), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    q.delete();
    mHalt  = 1'b0;
    mStall = 16'h0000;
    checkAll();
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 16'hA001, 16'h0060, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // stallCount saturation under a halt-blocked fetch
    cycle(1'b1, 16'h0000, 16'h0070, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++)
      cycle(1'b1, 16'h1234, 16'h0072, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 16'h0072, 1'b0, 1'b0);
    chk("stallSat", 32'(stallCount), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
